// File: rtl/haz_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
//   SEL_RF      : forward-select code meaning "read the register file"
//   calc_sel_w  : width of one forward-select field for a given stage count
//   fwd_sel_t   : forward-select field at the default stage count
//   haz_stg_t   : per-producer-stage view {valid, kill, wen, rdy, rd}
// Stage rd is carried at HAZ_RD_W bits so one struct serves any REG_AW up to
// that width; narrower addresses are zero-extended by the top.
package haz_pkg;

  localparam int SEL_RF      = 0;
  localparam int HAZ_RD_W    = 8;
  localparam int NUM_STG_DEF = 2;

  function automatic int calc_sel_w(input int num_stg);
    return (num_stg < 1) ? 1 : $clog2(num_stg + 1);
  endfunction

  localparam int SEL_W_DEF = calc_sel_w(NUM_STG_DEF);

  typedef logic [SEL_W_DEF-1:0] fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic                kill;
    logic                wen;
    logic                rdy;
    logic [HAZ_RD_W-1:0] rd;
  } haz_stg_t;

endpackage

// File: rtl/hazard_fwd_select.sv
// Forward selection for one source operand against NUM_STG producer stages.
//   i_rs        : source register address (zero-extended to HAZ_RD_W)
//   i_stg       : producer stage descriptors, index 0 = youngest
//   o_sel       : 0 = register file, k = stage k-1
//   o_stall_rdy : the selected stage has not produced its value yet
// Purely combinational.
module hazard_fwd_select
  import haz_pkg::*;
#(
  parameter int NUM_STG = 2,
  parameter int SEL_W   = calc_sel_w(NUM_STG)
) (
  input  logic [HAZ_RD_W-1:0]  i_rs,
  input  haz_stg_t             i_stg [NUM_STG],
  output logic [SEL_W-1:0]     o_sel,
  output logic                 o_stall_rdy
);

  // Walk from oldest to youngest so the youngest match is the last writer
  // and therefore wins. A zero rd never matches, which also keeps rs=0 on RF.
  always_comb begin
    o_sel       = SEL_W'(SEL_RF);
    o_stall_rdy = 1'b0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (i_stg[k].valid && !i_stg[k].kill && i_stg[k].wen &&
          (i_stg[k].rd != '0) && (i_stg[k].rd == i_rs)) begin
        o_sel       = SEL_W'(k + 1);
        o_stall_rdy = !i_stg[k].rdy;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding and hazard controller for the in-order pipeline.
//   i_src_rs        : NUM_SRC packed consumer source addresses
//   i_stg_*         : per producer stage valid/kill/wen/rd/rdy (0 = youngest)
//   i_issue_*       : long-latency op leaving ID (increments its rd's counter)
//   i_cpl_*         : long-latency op writing back (decrements its counter)
//   o_fwd_sel       : per source forward select, 0 = RF, k = stage k-1
//   o_stall         : hold ID/IF (load-use, in-flight long op, blocked issue)
//   o_issue_block   : issue target's pending counter is saturated
//   o_err_underflow : sticky, completion seen for a register with count 0
// Optional feature macro HAZ_PERF_CNT_EN adds saturating 32-bit counters
// o_stall_cycles and o_fwd_hits; without it those ports do not exist.
module hazard_scoreboard_unit
  import haz_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int NUM_STG = 2,
  parameter  int REG_AW  = 5,
  parameter  int PEND_W  = 2,
  localparam int SEL_W   = calc_sel_w(NUM_STG)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]  i_src_rs,
  input  logic [NUM_STG-1:0]         i_stg_valid,
  input  logic [NUM_STG-1:0]         i_stg_kill,
  input  logic [NUM_STG-1:0]         i_stg_wen,
  input  logic [NUM_STG*REG_AW-1:0]  i_stg_rd,
  input  logic [NUM_STG-1:0]         i_stg_rdy,
  input  logic                       i_issue_valid,
  input  logic [REG_AW-1:0]          i_issue_rd,
  input  logic                       i_cpl_valid,
  input  logic [REG_AW-1:0]          i_cpl_rd,
  output logic [NUM_SRC*SEL_W-1:0]   o_fwd_sel,
  output logic                       o_stall,
  output logic                       o_issue_block,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]                o_stall_cycles,
  output logic [31:0]                o_fwd_hits,
`endif
  output logic                       o_err_underflow
);

  localparam int NUM_REG = 2 ** REG_AW;

  haz_stg_t                         stg [NUM_STG];
  logic [NUM_REG-1:0][PEND_W-1:0]   pend_q, pend_d;
  logic                             err_underflow_q, err_underflow_d;
  logic [NUM_SRC-1:0]               stall_rdy;
  logic [NUM_SRC-1:0]               stall_pend;
  logic                             issue_inc;
  logic                             cpl_hit;

  // ---------------- stage descriptors ----------------
  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    assign stg[k] = '{valid: i_stg_valid[k],
                      kill:  i_stg_kill[k],
                      wen:   i_stg_wen[k],
                      rdy:   i_stg_rdy[k],
                      rd:    HAZ_RD_W'(i_stg_rd[k*REG_AW +: REG_AW])};
  end

  // ---------------- per-source forwarding ----------------
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic [SEL_W-1:0]  sel;

    assign rs = i_src_rs[s*REG_AW +: REG_AW];

    hazard_fwd_select #(
      .NUM_STG (NUM_STG),
      .SEL_W   (SEL_W)
    ) u_sel (
      .i_rs        (HAZ_RD_W'(rs)),
      .i_stg       (stg),
      .o_sel       (sel),
      .o_stall_rdy (stall_rdy[s])
    );

    assign o_fwd_sel[s*SEL_W +: SEL_W] = sel;
    // Long op issued but not yet visible in any forwardable stage.
    // pend_q[0] is held at zero, so rs=0 never stalls here.
    assign stall_pend[s] = (sel == SEL_W'(SEL_RF)) && (pend_q[rs] != '0);
  end

  // ---------------- issue block and stall ----------------
  assign o_issue_block   = i_issue_valid && (pend_q[i_issue_rd] == '1);
  assign o_stall         = (|stall_rdy) || (|stall_pend) || o_issue_block;
  assign o_err_underflow = err_underflow_q;

  // ---------------- pending counters ----------------
  assign issue_inc = i_issue_valid && (i_issue_rd != '0) && !o_issue_block;
  assign cpl_hit   = i_cpl_valid && (i_cpl_rd != '0);

  // Same-rd issue and completion in one cycle cancel: the count is left as
  // is and no underflow is flagged even at zero. A blocked issue never
  // counts, so its completion partner decrements normally.
  always_comb begin
    pend_d          = pend_q;
    err_underflow_d = err_underflow_q;
    if (!(issue_inc && cpl_hit && (i_issue_rd == i_cpl_rd))) begin
      if (issue_inc) begin
        pend_d[i_issue_rd] = pend_q[i_issue_rd] + PEND_W'(1);
      end
      if (cpl_hit) begin
        if (pend_q[i_cpl_rd] != '0) begin
          pend_d[i_cpl_rd] = pend_q[i_cpl_rd] - PEND_W'(1);
        end else begin
          err_underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q          <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      pend_q          <= pend_d;
      err_underflow_q <= err_underflow_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // ---------------- performance counters ----------------
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_hits_q, fwd_hits_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_hits_d     = fwd_hits_q;
    if (o_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if ((|o_fwd_sel) && (fwd_hits_q != '1)) begin
      fwd_hits_d = fwd_hits_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
      fwd_hits_q     <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_hits_q     <= fwd_hits_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_fwd_hits     = fwd_hits_q;
`endif

endmodule
